timer_scheduler: RTL
====================

TIMER_SCHEDULER -- requirements
Module: timer_scheduler

Interface
REQ-001 Parameter: WIDTH, default 16, bit width of each channel period and count.
REQ-002 Parameter: NCH, fixed at 4, number of timer channels; other values are not supported.
REQ-003 clk  input  1  single system clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 msTick  input  1  millisecond timebase level (square wave, same clock domain); each rising edge is one tick.
REQ-006 req  input  4  per-channel load request; held high until the matching ack.
REQ-007 reqPeriod  input  4*WIDTH  per-channel period in ticks; channel i uses bits [i*WIDTH +: WIDTH].
REQ-008 reqPeriodic  input  4  per-channel mode: 1 = auto-reload, 0 = one-shot.
REQ-009 cancel  input  4  per-channel level cancel.
REQ-010 ack  output  4  registered one-cycle load acknowledge.
REQ-011 active  output  4  channel armed and counting.
REQ-012 expire  output  4  registered one-cycle expiry pulse.

Function
REQ-013 Tick strobe: tickPrev <= msTick and strobe <= msTick & ~tickPrev, both registered; one strobe per msTick rising edge.
REQ-014 Arbitration: at most one channel is granted per cycle.
REQ-015 Eligible channels are those with req[i]=1 and ack[i]=0.
REQ-016 Grant is round-robin, searching upward (with wrap) from the channel after the last grant; the pointer starts at 0 after reset.
REQ-017 A granted channel i gets ack[i]=1 for exactly the following cycle.
REQ-018 On grant of channel i, its count and reload register load reqPeriod[i], its periodic flag loads reqPeriodic[i], and active[i] <= 1 (all at the same edge as ack[i]).
REQ-019 A grant with reqPeriod[i]=0 is still acked, but sets active[i] <= 0 and produces no expire.
REQ-020 Countdown: when strobe=1, each active channel not being loaded or cancelled in that cycle updates its count.
REQ-021 Countdown when count > 1: count decrements by 1.
REQ-022 Countdown when count == 1: expire[i] <= 1 for one cycle; periodic channels reload count and stay active; one-shot channels clear active[i].
REQ-023 Latency: a period-N load expires on the edge following the Nth strobe after the load edge, i.e. the edge after the cycle in which strobe is high for the Nth msTick rising edge.
REQ-024 Periodic expiry then recurs every N strobes.
REQ-025 Load vs strobe on the same channel in the same cycle: the load wins and the strobe is ignored for that channel.
REQ-026 Cancel: cancel[i]=1 sets active[i] <= 0 and suppresses any expire[i] that would have fired in that cycle.
REQ-027 Cancel with a concurrent grant to the same channel: the grant is acked, but cancel wins (channel ends inactive).
REQ-028 Count arithmetic is unsigned WIDTH bits; count never wraps because decrement occurs only when count > 1.
REQ-029 Channels are independent; multiple expire bits may assert in the same cycle.

Reset
REQ-030 While reset=1: ack, active, expire, strobe, all counts and reload registers, and the periodic flags are 0; the round-robin pointer is 0.
REQ-031 tickPrev resets to 1 so that a high msTick at release produces no spurious strobe.
REQ-032 Reset asserted mid-count aborts every channel immediately with no expire; requesters must re-request after release.

Verification
REQ-033 One-shot: ch0 load period 3, then 3 msTick rising edges -> single expire[0] pulse on the edge after the third strobe, active[0] falls on the same edge, no further pulses.
REQ-034 Periodic: ch2 load period 2 periodic, 7 ticks -> expire[2] after ticks 2, 4, 6 (3 pulses); active[2] stays 1.
REQ-035 Arbitration: req=4'b1111 asserted together and held until each ack -> acks in order ch0, ch1, ch2, ch3, one per cycle, each a single-cycle pulse; next simultaneous round starts at ch0 again.
REQ-036 Cancel race: ch1 period 1 loaded, cancel[1]=1 in the strobe cycle -> no expire[1], active[1]=0.
REQ-037 Zero period plus load-vs-strobe: ch3 with reqPeriod=0 -> ack[3]=1, active[3]=0, no expire.
REQ-038 Reload coincident with strobe: ch3 reloaded in a strobe cycle -> count equals the new period, not period-1.
REQ-039 Reset mid-operation: reset asserted at count=1 just before a strobe -> no expire; all outputs 0 asynchronously.
REQ-040 Reset release with msTick=1 -> no strobe until the next msTick rising edge.

Source files
------------

// File: rtl/timer_scheduler_if.sv
// Request/acknowledge and status bundle between the timer scheduler and its requesters.
interface timer_scheduler_if #(
  parameter int WIDTH = 16
);
  logic               msTick;
  logic [3:0]         req;
  logic [4*WIDTH-1:0] reqPeriod;
  logic [3:0]         reqPeriodic;
  logic [3:0]         cancel;
  logic [3:0]         ack;
  logic [3:0]         active;
  logic [3:0]         expire;

  modport master (
    output msTick, req, reqPeriod, reqPeriodic, cancel,
    input  ack, active, expire
  );

  modport slave (
    input  msTick, req, reqPeriod, reqPeriodic, cancel,
    output ack, active, expire
  );
endinterface

// File: rtl/timer_scheduler.sv
// Four-channel millisecond timer: round-robin load arbitration, one-shot or
// auto-reload countdown on msTick rising edges, per-channel cancel.
module timer_scheduler #(
  parameter int WIDTH = 16,
  parameter int NCH   = 4
) (
  input  logic              clk,
  input  logic              reset,
  timer_scheduler_if.slave  bus
);

  localparam int PW = $clog2(NCH);

  typedef logic [WIDTH-1:0] cnt_t;
  typedef logic [PW-1:0]    ptr_t;

  logic             tick_prev_q, tick_prev_d;
  logic             strobe_q, strobe_d;
  ptr_t             rr_ptr_q, rr_ptr_d;
  logic [NCH-1:0]   ack_q, ack_d;
  logic [NCH-1:0]   active_q, active_d;
  logic [NCH-1:0]   expire_q, expire_d;
  logic [NCH-1:0]   periodic_q, periodic_d;
  cnt_t             count_q [NCH];
  cnt_t             count_d [NCH];
  cnt_t             reload_q [NCH];
  cnt_t             reload_d [NCH];

  logic [NCH-1:0]   eligible;
  logic [NCH-1:0]   grant;
  logic             grant_vld;
  ptr_t             grant_idx;
  ptr_t             idx_v;
  cnt_t             period_v;

  // Round-robin search upward from the pointer; pointer arithmetic wraps naturally.
  always_comb begin
    eligible  = bus.req & ~ack_q;
    grant_vld = 1'b0;
    grant_idx = '0;
    idx_v     = '0;
    grant     = '0;
    for (int unsigned k = 0; k < NCH; k++) begin
      idx_v = rr_ptr_q + ptr_t'(k);
      if (!grant_vld && eligible[idx_v]) begin
        grant_vld = 1'b1;
        grant_idx = idx_v;
      end
    end
    if (grant_vld) grant[grant_idx] = 1'b1;
  end

  always_comb begin
    tick_prev_d = bus.msTick;
    strobe_d    = bus.msTick & ~tick_prev_q;
    rr_ptr_d    = grant_vld ? grant_idx + ptr_t'(1) : rr_ptr_q;
    ack_d       = grant;
    expire_d    = '0;
    active_d    = active_q;
    periodic_d  = periodic_q;
    count_d     = count_q;
    reload_d    = reload_q;
    period_v    = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      period_v = bus.reqPeriod[i*WIDTH +: WIDTH];
      if (grant[i]) begin
        count_d[i]    = period_v;
        reload_d[i]   = period_v;
        periodic_d[i] = bus.reqPeriodic[i];
        active_d[i]   = (period_v != '0);
      end else if (strobe_q && active_q[i] && !bus.cancel[i]) begin
        if (count_q[i] > cnt_t'(1)) begin
          count_d[i] = count_q[i] - cnt_t'(1);
        end else begin
          expire_d[i] = 1'b1;
          if (periodic_q[i]) count_d[i] = reload_q[i];
          else               active_d[i] = 1'b0;
        end
      end
      // Cancel overrides both a concurrent load and a pending expiry.
      if (bus.cancel[i]) active_d[i] = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tick_prev_q <= 1'b1;
      strobe_q    <= 1'b0;
      rr_ptr_q    <= '0;
      ack_q       <= '0;
      active_q    <= '0;
      expire_q    <= '0;
      periodic_q  <= '0;
      for (int unsigned i = 0; i < NCH; i++) begin
        count_q[i]  <= '0;
        reload_q[i] <= '0;
      end
    end else begin
      tick_prev_q <= tick_prev_d;
      strobe_q    <= strobe_d;
      rr_ptr_q    <= rr_ptr_d;
      ack_q       <= ack_d;
      active_q    <= active_d;
      expire_q    <= expire_d;
      periodic_q  <= periodic_d;
      count_q     <= count_d;
      reload_q    <= reload_d;
    end
  end

  assign bus.ack    = ack_q;
  assign bus.active = active_q;
  assign bus.expire = expire_q;

endmodule
